alu_arbiter: RTL



---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_arbiter_if.sv | 27 ++
 rtl/alu_arbiter_alu.sv | 34 +++
 rtl/alu_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: opcodes, NZCV bit positions, FSM states.
package alu_pkg;

  localparam int unsigned DW = 32;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_ORR = 2'b11;

  localparam int unsigned FLG_N = 0;
  localparam int unsigned FLG_Z = 1;
  localparam int unsigned FLG_C = 2;
  localparam int unsigned FLG_V = 3;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters, the shared ALU arbiter and the result consumer.
interface alu_arbiter_if import alu_pkg::*; ;

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0][DW-1:0] req_a;
  logic [1:0][DW-1:0] req_b;
  logic [1:0][1:0]    req_op;
  logic [1:0]         req_setflags;

  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [DW-1:0]      rsp_c;
  logic [3:0]         rsp_flags;

  modport master (
    output req_valid, req_a, req_b, req_op, req_setflags, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_c, rsp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_setflags, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_c, rsp_flags
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU: ADD/SUB/AND/ORR with NZCV flags.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  output logic [31:0] c,
  output logic [3:0]  flags
);

  logic [31:0] bx;
  logic [32:0] sum;

  always_comb begin
    // SUB shares the adder as a + ~b + 1, so C is the no-borrow indication
    bx    = (op == OP_SUB) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, bx} + {32'b0, (op == OP_SUB)};
    c     = '0;
    flags = '0;
    unique case (op)
      OP_ADD, OP_SUB: begin
        c            = sum[31:0];
        flags[FLG_C] = sum[32];
        flags[FLG_V] = (a[31] == bx[31]) && (sum[31] != a[31]);
      end
      OP_AND:  c = a & b;
      default: c = a | b;
    endcase
    flags[FLG_N] = c[31];
    flags[FLG_Z] = (c == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter around one shared ALU; owns the NZCV register.
// Define ALU_ARB_RR_EN for round-robin grant; default is fixed priority to port 0.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 2
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus,
  output logic [3:0]    nzcv,
  output logic          busy
);

  arb_state_t state_q, state_d;

  logic [NREQ-1:0]  grant;
  logic             winner;

  logic [WIDTH-1:0] lat_a, lat_b;
  logic [1:0]       lat_op;
  logic             lat_sf;
  logic             lat_id;

  logic [31:0]      alu_c;
  logic [3:0]       alu_flags;

  logic             rsp_valid_q, rsp_id_q;
  logic [31:0]      rsp_c_q;
  logic [3:0]       rsp_flags_q, nzcv_q;

`ifdef ALU_ARB_RR_EN
  logic rr_ptr;

  always_comb begin
    grant = '0;
    if (state_q == IDLE) begin
      if (bus.req_valid[rr_ptr])       grant[rr_ptr]  = 1'b1;
      else if (bus.req_valid[~rr_ptr]) grant[~rr_ptr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       rr_ptr <= 1'b0;
    else if (|grant) rr_ptr <= ~winner;
  end
`else
  always_comb begin
    grant = '0;
    if (state_q == IDLE) begin
      if (bus.req_valid[0])      grant[0] = 1'b1;
      else if (bus.req_valid[1]) grant[1] = 1'b1;
    end
  end
`endif

  assign winner = grant[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|grant) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_a       <= '0;
      lat_b       <= '0;
      lat_op      <= '0;
      lat_sf      <= 1'b0;
      lat_id      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_c_q     <= '0;
      rsp_flags_q <= '0;
      nzcv_q      <= '0;
    end else begin
      if (|grant) begin
        lat_a  <= bus.req_a[winner];
        lat_b  <= bus.req_b[winner];
        lat_op <= bus.req_op[winner];
        lat_sf <= bus.req_setflags[winner];
        lat_id <= winner;
      end
      if (state_q == EXEC) begin
        rsp_valid_q <= 1'b1;
        rsp_c_q     <= alu_c;
        rsp_flags_q <= alu_flags;
        rsp_id_q    <= lat_id;
        if (lat_sf) nzcv_q <= alu_flags;
      end else if (state_q == RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  alu u_alu (
    .a     (lat_a),
    .b     (lat_b),
    .op    (lat_op),
    .c     (alu_c),
    .flags (alu_flags)
  );

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign nzcv          = nzcv_q;
  assign busy          = (state_q != IDLE);

endmodule
